// File: rtl/data_store_buf_pkg.sv
// Shared constants for the core data-port store buffer.
package data_store_buf_pkg;

  localparam int unsigned STORE_BUF_DEPTH = 4;
  localparam int unsigned INST_ADDR_WIDTH = 32;
  localparam int unsigned REG_DATA_WIDTH  = 32;

endpackage

// File: rtl/data_store_buf_if.sv
// Core data port plus memory read/write port of the store buffer.
// The slave side is the buffer; the master side is the core/memory environment.
interface data_store_buf_if
  import data_store_buf_pkg::*;
#(
  parameter int unsigned AW = INST_ADDR_WIDTH,
  parameter int unsigned DW = REG_DATA_WIDTH
);
  logic          data_ce_i;
  logic          data_we_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_i;
  logic [DW-1:0] data_o;
  logic [AW-1:0] mem_raddr_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [AW-1:0] mem_waddr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;

  modport slave (
    input  data_ce_i, data_we_i, data_addr_i, data_i, mem_rdata_i, mem_gnt_i,
    output data_o, mem_raddr_o, mem_req_o, mem_waddr_o, mem_wdata_o,
           full_o, empty_o, overflow_o
  );

  modport master (
    output data_ce_i, data_we_i, data_addr_i, data_i, mem_rdata_i, mem_gnt_i,
    input  data_o, mem_raddr_o, mem_req_o, mem_waddr_o, mem_wdata_o,
           full_o, empty_o, overflow_o
  );
endinterface

// File: rtl/data_store_buf_match.sv
// Combinational youngest-match search over the valid store-buffer entries.
module store_buf_match
  import data_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = STORE_BUF_DEPTH,
  parameter int unsigned AW    = INST_ADDR_WIDTH,
  parameter int unsigned DW    = REG_DATA_WIDTH
) (
  input  logic [AW-1:0]              addr_i,
  input  logic [AW-1:0]              entry_addr_i [DEPTH],
  input  logic [DW-1:0]              entry_data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [$clog2(DEPTH):0]     count_i,
  output logic                       hit_o,
  output logic [DW-1:0]              hit_data_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest; the last match written wins, i.e. the youngest.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if ((CW'(i) < count_i) && (entry_addr_i[idx] == addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entry_data_i[idx];
      end
    end
  end
endmodule

// File: rtl/data_store_buf.sv
// Store FIFO between the core data port and the arbitrated data-memory write port.
// Define STORE_BUF_FWD_EN to forward loads from the youngest matching buffered store.
module data_store_buf
  import data_store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = STORE_BUF_DEPTH,
  parameter int unsigned AW    = INST_ADDR_WIDTH,
  parameter int unsigned DW    = REG_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  data_store_buf_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic full_c, empty_c, store_c, push_c, pop_c;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign store_c = bus.data_ce_i & bus.data_we_i;
  assign pop_c   = ~empty_c & bus.mem_gnt_i;
  assign push_c  = store_c & (~full_c | pop_c);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_c) tail_d = tail_q + PW'(1);
    if (pop_c)  head_d = head_q + PW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (store_c && !push_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage is cleared so the write-port payload reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push_c) begin
      addr_q[tail_q] <= bus.data_addr_i;
      data_q[tail_q] <= bus.data_i;
    end
  end

  assign bus.mem_req_o   = ~empty_c;
  assign bus.mem_waddr_o = addr_q[head_q];
  assign bus.mem_wdata_o = data_q[head_q];
  assign bus.full_o      = full_c;
  assign bus.empty_o     = empty_c;
  assign bus.overflow_o  = overflow_q;
  assign bus.mem_raddr_o = bus.data_addr_i;

`ifdef STORE_BUF_FWD_EN
  logic          hit_c;
  logic [DW-1:0] hit_data_c;

  store_buf_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_match (
    .addr_i       (bus.data_addr_i),
    .entry_addr_i (addr_q),
    .entry_data_i (data_q),
    .head_i       (head_q),
    .count_i      (count_q),
    .hit_o        (hit_c),
    .hit_data_o   (hit_data_c)
  );

  assign bus.data_o = (bus.data_ce_i & ~bus.data_we_i & hit_c) ? hit_data_c : bus.mem_rdata_i;
`else
  assign bus.data_o = bus.mem_rdata_i;
`endif
endmodule

// File: tb/tb_data_store_buf.sv
// Directed bench for data_store_buf: reset, drain order, overflow, full-with-pop, load forwarding.
module tb_data_store_buf;
  import data_store_buf_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  data_store_buf_if #(.AW(32), .DW(32)) bus ();

  data_store_buf #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.data_ce_i   = 1'b0;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = '0;
    bus.data_i      = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.data_ce_i   = 1'b1;
    bus.data_we_i   = 1'b1;
    bus.data_addr_i = a;
    bus.data_i      = d;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   64'(bus.mem_req_o),   64'd0);
    check({tag, "_empty"}, 64'(bus.empty_o),     64'd1);
    check({tag, "_full"},  64'(bus.full_o),      64'd0);
    check({tag, "_ovf"},   64'(bus.overflow_o),  64'd0);
    check({tag, "_waddr"}, 64'(bus.mem_waddr_o), 64'd0);
    check({tag, "_wdata"}, 64'(bus.mem_wdata_o), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_a [4];
    logic [31:0] fwd_exp;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    idle();
    bus.mem_gnt_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single store with grant already high: presented next cycle, popped at that edge.
    bus.mem_gnt_i = 1'b1;
    store(32'h100, 32'hDEADBEEF);
    step();
    idle();
    check("single_req",   64'(bus.mem_req_o),   64'd1);
    check("single_waddr", 64'(bus.mem_waddr_o), 64'h100);
    check("single_wdata", 64'(bus.mem_wdata_o), 64'hDEADBEEF);
    step();
    check("single_empty", 64'(bus.empty_o),   64'd1);
    check("single_noreq", 64'(bus.mem_req_o), 64'd0);

    // Full with a simultaneous pop: store accepted, count stays at DEPTH.
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'(i * 4), 32'(32'hA0 + i));
      step();
    end
    idle();
    check("fp_full", 64'(bus.full_o), 64'd1);
    bus.mem_gnt_i = 1'b1;
    store(32'h40, 32'h4040);
    step();
    idle();
    bus.mem_gnt_i = 1'b0;
    check("fp_full_after", 64'(bus.full_o),     64'd1);
    check("fp_ovf",        64'(bus.overflow_o), 64'd0);
    exp_a[0] = 32'h4; exp_a[1] = 32'h8; exp_a[2] = 32'hC; exp_a[3] = 32'h40;
    bus.mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fp_drain%0d_addr", i), 64'(bus.mem_waddr_o), 64'(exp_a[i]));
      check($sformatf("fp_drain%0d_req", i),  64'(bus.mem_req_o),   64'd1);
      step();
    end
    check("fp_wdata_last_empty", 64'(bus.empty_o), 64'd1);

    // Fill then overflow: fifth store dropped, sticky flag, four writes in order.
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ov_full_before", 64'(bus.full_o), 64'd1);
      store(32'(i * 4), 32'(32'hB0 + i));
      step();
    end
    idle();
    check("ov_flag", 64'(bus.overflow_o), 64'd1);
    check("ov_full", 64'(bus.full_o),     64'd1);
    bus.mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ov_drain%0d_addr", i), 64'(bus.mem_waddr_o), 64'(i * 4));
      check($sformatf("ov_drain%0d_data", i), 64'(bus.mem_wdata_o), 64'(32'hB0 + i));
      step();
    end
    check("ov_empty",  64'(bus.empty_o),    64'd1);
    check("ov_noreq",  64'(bus.mem_req_o),  64'd0);
    check("ov_sticky", 64'(bus.overflow_o), 64'd1);

    // Load forwarding from the youngest same-address store.
    bus.mem_gnt_i = 1'b0;
    store(32'h20, 32'h1);
    step();
    store(32'h20, 32'h2);
    step();
    bus.data_ce_i   = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = 32'h20;
    bus.mem_rdata_i = 32'h55;
    #1;
`ifdef STORE_BUF_FWD_EN
    fwd_exp = 32'h2;
`else
    fwd_exp = 32'h55;
`endif
    check("ld_hit_data",  64'(bus.data_o),      64'(fwd_exp));
    check("ld_raddr",     64'(bus.mem_raddr_o), 64'h20);
    bus.data_addr_i = 32'h24;
    #1;
    check("ld_miss_data", 64'(bus.data_o),      64'h55);
    check("ld_raddr2",    64'(bus.mem_raddr_o), 64'h24);
    idle();
    step();
    check("ld_pending_req", 64'(bus.mem_req_o), 64'd1);

    // Asynchronous reset mid-cycle discards the buffered stores at once.
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    #1;
    rst = 1'b0;
    bus.mem_gnt_i = 1'b1;
    step();
    check("arst_noreq1", 64'(bus.mem_req_o), 64'd0);
    step();
    check("arst_noreq2", 64'(bus.mem_req_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
